// File: rtl/bus_merge_arbiter.sv
// bus_merge_arbiter: merges a low-segment requester (A) and a high-segment
// requester (B) onto one shared addr/data bus. Each port has a small FIFO;
// a round-robin arbiter feeds a registered output stage with valid/ready.
// Beats whose address falls outside the port's segment are consumed,
// dropped, flagged for one cycle and counted in a saturating counter.
module bus_merge_arbiter #(
  parameter int             AW    = 8,
  parameter int             DW    = 16,
  parameter int             DEPTH = 2,
  parameter logic [AW-1:0]  A_MAX = 8'h3F
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          vld_a,
  output logic          rdy_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  input  logic          vld_b,
  output logic          rdy_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  output logic          vld,
  input  logic          rdy,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          src,
  output logic          err_a,
  output logic          err_b,
  output logic [7:0]    drop_cnt
);

  localparam int BW = AW + DW;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Saturating add of up to two dropped beats to the drop counter.
  function automatic logic [7:0] sat_add(input logic [7:0] cur, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cur} + {8'b0, inc[0]} + {8'b0, inc[1]};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic              rdy_en;
  logic [1:0]        in_vld;
  logic [1:0][BW-1:0] in_beat;
  logic [1:0][BW-1:0] head;
  logic [1:0]        seg_ok;
  logic [1:0]        port_rdy;
  logic [1:0]        acc;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        drop;
  logic [1:0]        ne;
  logic [1:0]        full;
  logic              prio;
  logic              gnt;
  logic              load_ok;
  logic              load;

  assign in_vld     = {vld_b, vld_a};
  assign in_beat[0] = {addr_a, data_a};
  assign in_beat[1] = {addr_b, data_b};
  assign seg_ok[0]  = (addr_a <= A_MAX);
  assign seg_ok[1]  = (addr_b >  A_MAX);

  // Ready is gated off until the first clock edge after reset release and
  // depends only on FIFO occupancy, never on a same-cycle pop.
  assign port_rdy = {2{rdy_en}} & ~full;
  assign rdy_a    = port_rdy[0];
  assign rdy_b    = port_rdy[1];
  assign acc      = in_vld & port_rdy;
  assign push     = acc & seg_ok;
  assign drop     = acc & ~seg_ok;

  // Enables port readiness one edge after reset deasserts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  for (genvar p = 0; p < 2; p++) begin : g_fifo
    logic [BW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // FIFO storage; contents are qualified by the count, so no reset needed.
    always_ff @(posedge clk) begin
      if (push[p]) mem[wr_ptr] <= in_beat[p];
    end

    // FIFO pointers and occupancy; push+pop in one cycle keeps the count.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[p]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[p])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[p], pop[p]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    assign head[p] = mem[rd_ptr];
    assign ne[p]   = (cnt != '0);
    assign full[p] = (cnt == FULL);
  end

  assign load_ok = !vld || rdy;
  assign load    = load_ok && (ne != 2'b00);

  // Round-robin grant: alternate when both ports have data, otherwise take
  // whichever port is non-empty.
  always_comb begin
    gnt = 1'b0;
    if (ne[0] && ne[1]) gnt = prio;
    else if (ne[1])     gnt = 1'b1;
    pop = 2'b00;
    if (load) pop = gnt ? 2'b10 : 2'b01;
  end

  // Arbiter pointer: names the port preferred on the next contested grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     prio <= 1'b0;
    else if (load) prio <= ~gnt;
  end

  // Output register: load on a free slot, hold under backpressure, and
  // return to all-zero when it empties.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld  <= 1'b0;
      addr <= '0;
      data <= '0;
      src  <= 1'b0;
    end else if (load_ok) begin
      if (load) begin
        vld          <= 1'b1;
        {addr, data} <= head[gnt];
        src          <= gnt;
      end else begin
        vld  <= 1'b0;
        addr <= '0;
        data <= '0;
        src  <= 1'b0;
      end
    end
  end

  // Drop flags for one cycle and the saturating drop counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_a    <= 1'b0;
      err_b    <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      err_a    <= drop[0];
      err_b    <= drop[1];
      drop_cnt <= sat_add(drop_cnt, drop);
    end
  end

endmodule

// File: tb/tb_bus_merge_arbiter.sv
// Bench for bus_merge_arbiter: directed steps plus random traffic, checked
// every cycle against a queue-based reference model of the merge rules.
module tb_bus_merge_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          vld_a = 1'b0;
  logic          rdy_a;
  logic [AW-1:0] addr_a = '0;
  logic [DW-1:0] data_a = '0;
  logic          vld_b = 1'b0;
  logic          rdy_b;
  logic [AW-1:0] addr_b = '0;
  logic [DW-1:0] data_b = '0;
  logic          vld;
  logic          rdy = 1'b0;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          src;
  logic          err_a;
  logic          err_b;
  logic [7:0]    drop_cnt;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [23:0] qa[$];
  logic [23:0] qb[$];
  bit          m_vld;
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  bit          m_src;
  bit          m_last;
  bit          m_started;
  bit          m_err_a;
  bit          m_err_b;
  int          m_drop;

  bus_merge_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .A_MAX(8'h3F)) dut (
    .clk(clk), .rstn(rstn),
    .vld_a(vld_a), .rdy_a(rdy_a), .addr_a(addr_a), .data_a(data_a),
    .vld_b(vld_b), .rdy_b(rdy_b), .addr_b(addr_b), .data_b(data_b),
    .vld(vld), .rdy(rdy), .addr(addr), .data(data), .src(src),
    .err_a(err_a), .err_b(err_b), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_vld = 0; m_addr = '0; m_data = '0; m_src = 0;
    m_last = 1;  // so that A wins the first contested grant
    m_started = 0; m_err_a = 0; m_err_b = 0; m_drop = 0;
  endtask

  task automatic model_edge(input bit va, input logic [7:0] aa, input logic [15:0] da,
                            input bit vb, input logic [7:0] ab, input logic [15:0] db,
                            input bit r);
    bit ra, rb, acc_a, acc_b;
    int g;
    logic [23:0] beat;
    ra = m_started && (qa.size() < DEPTH);
    rb = m_started && (qb.size() < DEPTH);
    acc_a = va && ra;
    acc_b = vb && rb;
    if (!m_vld || r) begin
      g = -1;
      if (qa.size() > 0 && qb.size() > 0) g = m_last ? 0 : 1;
      else if (qa.size() > 0)             g = 0;
      else if (qb.size() > 0)             g = 1;
      if (g >= 0) begin
        if (g == 0) beat = qa.pop_front();
        else        beat = qb.pop_front();
        m_vld = 1; m_addr = beat[23:16]; m_data = beat[15:0];
        m_src = (g == 1); m_last = (g == 1);
      end else begin
        m_vld = 0; m_addr = '0; m_data = '0; m_src = 0;
      end
    end
    if (acc_a && aa <= 8'h3F) qa.push_back({aa, da});
    if (acc_b && ab >  8'h3F) qb.push_back({ab, db});
    m_err_a = acc_a && (aa > 8'h3F);
    m_err_b = acc_b && (ab <= 8'h3F);
    m_drop = m_drop + int'(m_err_a) + int'(m_err_b);
    if (m_drop > 255) m_drop = 255;
    m_started = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".vld"},   32'(vld),      32'(m_vld));
    chk({tag, ".addr"},  32'(addr),     32'(m_addr));
    chk({tag, ".data"},  32'(data),     32'(m_data));
    chk({tag, ".src"},   32'(src),      32'(m_src));
    chk({tag, ".rdy_a"}, 32'(rdy_a),    32'(m_started && qa.size() < DEPTH));
    chk({tag, ".rdy_b"}, 32'(rdy_b),    32'(m_started && qb.size() < DEPTH));
    chk({tag, ".err_a"}, 32'(err_a),    32'(m_err_a));
    chk({tag, ".err_b"}, 32'(err_b),    32'(m_err_b));
    chk({tag, ".drop"},  32'(drop_cnt), 32'(m_drop));
  endtask

  // Drive inputs, advance one edge, update the model, then sample 1 time unit later.
  task automatic step(input string tag,
                      input bit va, input logic [7:0] aa, input logic [15:0] da,
                      input bit vb, input logic [7:0] ab, input logic [15:0] db,
                      input bit r);
    vld_a = va; addr_a = aa; data_a = da;
    vld_b = vb; addr_b = ab; data_b = db;
    rdy = r;
    @(posedge clk);
    model_edge(va, aa, da, vb, ab, db, r);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 8'h00, 16'h0, 0, 8'h00, 16'h0, 1);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rstn = 1'b1;
    idle("post_reset", 2);

    // single A beat
    step("single", 1, 8'h10, 16'hBEEF, 0, 8'h00, 16'h0, 1);
    chk("single.bubble", 32'(vld), 32'd0);
    step("single", 0, 8'h00, 16'h0, 0, 8'h00, 16'h0, 1);
    chk("single.vld_out", 32'({vld, addr, data}), 32'({1'b1, 8'h10, 16'hBEEF}));
    idle("single_drain", 3);

    // A and B streaming together
    for (int i = 0; i < 20; i++)
      step("stream", 1, 8'(i + 1), 16'(16'hA000 + i), 1, 8'(8'h80 + i), 16'(16'hB000 + i), 1);
    idle("stream_drain", 6);

    // backpressure: three A beats fill FIFO plus output register
    for (int i = 0; i < 3; i++)
      step("hold_fill", 1, 8'(8'h20 + i), 16'(16'h1100 + i), 0, 8'h00, 16'h0, 0);
    chk("hold.rdy_a_low", 32'(rdy_a), 32'd0);
    for (int i = 0; i < 3; i++)
      step("hold", 0, 8'h00, 16'h0, 0, 8'h00, 16'h0, 0);
    chk("hold.stable", 32'({vld, addr, data}), 32'({1'b1, 8'h20, 16'h1100}));
    idle("hold_drain", 5);

    // simultaneous drops, then saturation
    step("drop2", 1, 8'h40, 16'h1, 1, 8'h3F, 16'h2, 1);
    chk("drop2.cnt", 32'(drop_cnt), 32'd2);
    step("drop2_after", 0, 8'h00, 16'h0, 0, 8'h00, 16'h0, 1);
    for (int i = 0; i < 150; i++)
      step("drop_sat", 1, 8'h40, 16'h3, 1, 8'h3F, 16'h4, 1);
    chk("drop_sat.cnt", 32'(drop_cnt), 32'd255);
    idle("drop_idle", 2);

    // segment boundaries
    step("bound", 1, 8'h3F, 16'h3F3F, 1, 8'h40, 16'h4040, 1);
    step("bound", 0, 8'h00, 16'h0, 1, 8'hFF, 16'hFFFF, 1);
    idle("bound_drain", 5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit va, vb, r;
      logic [7:0] aa, ab;
      va = 1'($urandom_range(0, 1));
      vb = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 3) != 0);
      aa = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
      ab = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(64, 255));
      step("rand", va, aa, 16'($urandom), vb, ab, 16'($urandom), r);
    end
    idle("rand_drain", 6);

    // reset with beats queued and output valid
    for (int i = 0; i < 3; i++)
      step("rst_fill", 1, 8'(8'h05 + i), 16'(16'h5500 + i), 0, 8'h00, 16'h0, 0);
    vld_a = 0;
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    #2;
    rstn = 1'b1;
    idle("rst_after", 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
